audio_level_meter: RTL
======================

Name: audio_level_meter

Overview:
- Converts a stream of signed PCM audio samples into an 18-segment thermometer bar, with a peak-hold dot, for the red LED bank.
- Sits directly upstream of the LED output register in the visualizer top level. It replaces the free-running shift pattern as the source of the LED word.
- Runs in the slow display clock domain. Samples arrive with a valid strobe; display updates are paced by a frame tick.

Parameters:
- SAMPLE_W, 16, sample width, two's complement.
- NUM_LEDS, 18, number of bar segments.
- DECAY_SHIFT, 4, envelope release per frame: env -= env >> DECAY_SHIFT.
- HOLD_FRAMES, 24, frames the peak dot is frozen before it starts falling.

Ports:
- clk  in  1  display clock.
- reset_bar  in  1  asynchronous, active-low reset.
- sample_in  in  SAMPLE_W  signed audio sample.
- sample_valid  in  1  sample_in is consumed on every cycle this is high; no backpressure.
- frame_tick  in  1  single-cycle pulse that closes the current measurement frame.
- led_bar  out  NUM_LEDS  bit i lit = segment i; bit 0 is the bottom segment.
- level  out  5  number of lit thermometer segments, 0..NUM_LEDS.
- peak_level  out  5  peak-hold position, 0..NUM_LEDS; 0 = no dot.
- frame_done  out  1  one-cycle pulse when led_bar/level/peak_level update.

Behaviour:
- Reset: clock is clk; reset is reset_bar, asynchronous, active-low. Reset clears to 0: frame_max, env, level, peak_level, hold_cnt, led_bar, frame_done. No reset state is observable after release except all zeros. Reset mid-frame discards the partial frame.
- Magnitude:
  - abs = |sample_in|, saturating: the most negative code (-32768) maps to 32767.
  - Result is an unsigned value of SAMPLE_W-1 bits.
- Frame accumulator:
  - On sample_valid, frame_max <= max(frame_max, abs).
  - If sample_valid and frame_tick occur in the same cycle, that sample belongs to the closing frame. The candidate is max(frame_max, abs), and frame_max clears to 0.
  - frame_tick with no samples in the frame gives candidate 0.
- Stage 1 (cycle after frame_tick), envelope update:
  - If candidate > env: env <= candidate (instant attack).
  - Else: d = env >> DECAY_SHIFT; if d == 0 and env > 0, then d = 1. env <= env - d.
  - env therefore always reaches 0 and never wraps.
- Stage 2 (second cycle after frame_tick), display update:
  - lvl = (env * (NUM_LEDS+1)) >> (SAMPLE_W-1), clamped to NUM_LEDS. Use a 21-bit product minimum.
  - level <= lvl.
  - If lvl >= peak_level: peak_level <= lvl and hold_cnt <= HOLD_FRAMES.
  - Else if hold_cnt > 0: hold_cnt decrements.
  - Else: peak_level decrements by 1, floor 0.
  - led_bar <= thermometer(lvl), meaning bits [lvl-1:0] set. In addition, bit (peak_level_new - 1) is set when peak_level_new > 0.
  - frame_done pulses in this cycle.
- Latency: frame_tick at cycle N gives new outputs visible at N+2.
- Back-to-back frame_tick on consecutive cycles is legal. Each tick is processed in order, pipelined.
- Outputs are stable between frame_done pulses.

Test Plan:
- Reset, then 3 frames with no samples -> led_bar = 0, level = 0, peak_level = 0. frame_done pulses exactly 2 cycles after each tick.
- One frame containing samples {100, -32768, 5} -> env = 32767, level = 18, led_bar = 18'h3FFFF, peak_level = 18.
- Following silent frame -> env = 30720, level = 17, led_bar = 18'h3FFFF (dot at bit 17). Peak holds for 24 frames, then falls 1 per frame.
- env = 15, silent frames -> env goes 15 → 14 → 13 … → 0, decaying by 1 per frame. Never negative, never wraps.
- Sample 16000 with sample_valid coincident with frame_tick -> counted in the closing frame (level = 9). The next frame starts from frame_max = 0.
- Assert reset_bar low mid-hold with level = 12 -> all outputs 0 immediately (asynchronous). The first frame after release behaves as from power-up.

Source files
------------

// File: rtl/audio_level_meter.sv
// Purpose: peak-reading level meter; turns signed PCM samples into an LED thermometer bar with a peak-hold dot.
// Latency: frame_tick in cycle N -> led_bar/level/peak_level/frame_done updated and visible in cycle N+2.
// Backpressure: none; every sample_valid cycle consumes sample_in, and back-to-back ticks pipeline in order.
//
// Ports:
//   clk, reset_bar      display clock, asynchronous active-low reset
//   sample_in           signed two's-complement sample, qualified by sample_valid
//   frame_tick          single-cycle pulse closing the current measurement frame
//   led_bar             bit i lit = segment i (bit 0 = bottom), bar plus peak dot
//   level, peak_level   lit segment count and peak-hold position (0 = no dot)
//   frame_done          one-cycle pulse coinciding with each display update
module audio_level_meter #(
  parameter int SAMPLE_W    = 16,
  parameter int NUM_LEDS    = 18,
  parameter int DECAY_SHIFT = 4,
  parameter int HOLD_FRAMES = 24
) (
  input  logic                clk,
  input  logic                reset_bar,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  input  logic                frame_tick,
  output logic [NUM_LEDS-1:0] led_bar,
  output logic [4:0]          level,
  output logic [4:0]          peak_level,
  output logic                frame_done
);

  localparam int MAG_W  = SAMPLE_W - 1;
  // Product must hold env * (NUM_LEDS+1); eight guard bits covers up to 255 segments.
  localparam int PROD_W = MAG_W + 8;
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

  logic [MAG_W-1:0]  frame_max;
  logic [MAG_W-1:0]  env;
  logic [HOLD_W-1:0] hold_cnt;
  logic              disp_upd;   // env was updated last cycle; refresh the display now

  logic [MAG_W-1:0]    mag;
  logic [MAG_W-1:0]    candidate;
  logic [MAG_W-1:0]    decay;
  logic [PROD_W-1:0]   prod;
  logic [PROD_W-1:0]   lvl_raw;
  logic [4:0]          lvl;
  logic [4:0]          peak_nxt;
  logic [HOLD_W-1:0]   hold_nxt;
  logic [NUM_LEDS-1:0] led_nxt;

  // Saturating magnitude. For a negative sample the low bits L give |x| = 2^MAG_W - L,
  // which is simply -L modulo 2^MAG_W; L == 0 is the most negative code and clips to full scale.
  always_comb begin
    mag = sample_in[MAG_W-1:0];
    if (sample_in[SAMPLE_W-1]) begin
      if (sample_in[MAG_W-1:0] == '0)
        mag = '1;
      else
        mag = '0 - sample_in[MAG_W-1:0];
    end
  end

  // A sample arriving together with frame_tick belongs to the closing frame.
  always_comb begin
    candidate = frame_max;
    if (sample_valid && (mag > frame_max))
      candidate = mag;
  end

  // Release step, forced to at least 1 so the envelope always drains to exactly 0.
  always_comb begin
    decay = env >> DECAY_SHIFT;
    if ((decay == '0) && (env != '0))
      decay = MAG_W'(1);
  end

  // Stage 1: frame accumulator and envelope.
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      frame_max <= '0;
      env       <= '0;
      disp_upd  <= 1'b0;
    end else begin
      disp_upd <= frame_tick;
      if (frame_tick) begin
        frame_max <= '0;
        if (candidate > env)
          env <= candidate;
        else
          env <= env - decay;
      end else if (sample_valid) begin
        frame_max <= candidate;
      end
    end
  end

  // Stage 2 combinational: scale envelope to segments, run peak-hold, build the LED word.
  always_comb begin
    prod    = PROD_W'(env) * PROD_W'(NUM_LEDS + 1);
    lvl_raw = prod >> MAG_W;
    if (lvl_raw > PROD_W'(NUM_LEDS))
      lvl = 5'(NUM_LEDS);
    else
      lvl = 5'(lvl_raw);

    peak_nxt = peak_level;
    hold_nxt = hold_cnt;
    if (lvl >= peak_level) begin
      peak_nxt = lvl;
      hold_nxt = HOLD_W'(HOLD_FRAMES);
    end else if (hold_cnt != '0) begin
      hold_nxt = hold_cnt - HOLD_W'(1);
    end else if (peak_level != '0) begin
      peak_nxt = peak_level - 5'd1;
    end

    led_nxt = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (i < int'(lvl))
        led_nxt[i] = 1'b1;
      if ((peak_nxt != '0) && (i == int'(peak_nxt) - 1))
        led_nxt[i] = 1'b1;
    end
  end

  // Stage 2 registers: outputs only move on a display update, so they stay stable between frame_done pulses.
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      level      <= '0;
      peak_level <= '0;
      hold_cnt   <= '0;
      led_bar    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= disp_upd;
      if (disp_upd) begin
        level      <= lvl;
        peak_level <= peak_nxt;
        hold_cnt   <= hold_nxt;
        led_bar    <= led_nxt;
      end
    end
  end

endmodule
